// File: rtl/timer_pkg.sv
// Shared constants for the serial delay timer command path: frame layout and
// sequencer state encodings.
package timer_pkg;

  localparam int DELAY_W    = 4;
  localparam int FRAME_BITS = 9;

  localparam logic [3:0] PREAMBLE = 4'b1101;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PREAMBLE  = 3'd1;
  localparam logic [2:0] ST_GUARD     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD   = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_ACK       = 3'd5;
  localparam logic [2:0] ST_GAP       = 3'd6;

endpackage

// File: rtl/timer_cmd_sequencer_cmd_fifo.sv
// Synchronous request FIFO; pointers wrap modulo DEPTH (power of two) and the
// count carries one extra bit so full and empty are unambiguous.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/timer_cmd_sequencer.sv
// Serialises queued 4-bit delay requests into framed commands for the serial
// delay timer, acknowledges each completion and guards against a stuck timer.
module timer_cmd_sequencer
  import timer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [DELAY_W-1:0] req_delay,
  output logic               req_ready,
  output logic               ser_data,
  output logic               ack,
  input  logic               tmr_counting,
  input  logic               tmr_done,
  output logic               busy,
  output logic [7:0]         cmd_done_cnt,
  output logic               timeout_err
);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]         state, state_d;
  logic [3:0]         bit_cnt, bit_cnt_d;
  logic [DELAY_W-1:0] cur_delay, cur_delay_d;
  logic [WD_W-1:0]    wd_cnt, wd_cnt_d;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [DELAY_W-1:0] fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               ser_d, ack_d, timeout_set, cnt_inc;
  logic [1:0]         pay_idx;

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DELAY_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid),
    .pop   (fifo_pop),
    .wdata (req_delay),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign req_ready = !fifo_full;
  assign busy      = (state != ST_IDLE);

  // bit_cnt spans the whole frame (preamble, guard, payload), so payload bits
  // are indexed from the frame end to send cur_delay MSB first.
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    cur_delay_d = cur_delay;
    wd_cnt_d    = wd_cnt;
    gap_cnt_d   = gap_cnt;
    fifo_pop    = 1'b0;
    timeout_set = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          cur_delay_d = fifo_head;
          bit_cnt_d   = '0;
          state_d     = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        bit_cnt_d = bit_cnt + 4'd1;
        if (bit_cnt == 4'd3) state_d = ST_GUARD;
      end
      ST_GUARD: begin
        bit_cnt_d = bit_cnt + 4'd1;
        state_d   = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        bit_cnt_d = bit_cnt + 4'd1;
        if (bit_cnt == 4'(FRAME_BITS - 1)) begin
          state_d  = ST_WAIT_DONE;
          wd_cnt_d = '0;
        end
      end
      ST_WAIT_DONE: begin
        if (tmr_done) begin
          state_d = ST_ACK;
        end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_set = 1'b1;
          state_d     = ST_GAP;
          gap_cnt_d   = '0;
        end else begin
          wd_cnt_d = wd_cnt + WD_W'(1);
        end
      end
      ST_ACK: begin
        cnt_inc   = 1'b1;
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else gap_cnt_d = gap_cnt + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    pay_idx = 2'(4'(FRAME_BITS - 1) - bit_cnt_d);
    ser_d   = 1'b0;
    if (state_d == ST_PREAMBLE)     ser_d = PREAMBLE[2'd3 - bit_cnt_d[1:0]];
    else if (state_d == ST_PAYLOAD) ser_d = cur_delay_d[pay_idx];
    ack_d = (state_d == ST_ACK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      cur_delay    <= '0;
      wd_cnt       <= '0;
      gap_cnt      <= '0;
      ser_data     <= 1'b0;
      ack          <= 1'b0;
      cmd_done_cnt <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      cur_delay <= cur_delay_d;
      wd_cnt    <= wd_cnt_d;
      gap_cnt   <= gap_cnt_d;
      ser_data  <= ser_d;
      ack       <= ack_d;
      if (cnt_inc)     cmd_done_cnt <= cmd_done_cnt + 8'd1;
      if (timeout_set) timeout_err  <= 1'b1;
    end
  end

  // A timer reporting done is no longer counting; the FIFO never overfills.
  a_done_not_counting: assert property (@(posedge clk) disable iff (reset)
    tmr_done |-> !tmr_counting);
  a_fifo_count_range: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_timer_cmd_sequencer.sv
// Randomised bench for timer_cmd_sequencer against a cycle-timeline reference
// model (frame start, wait resolution and gap end as absolute cycle numbers).
module tb_timer_cmd_sequencer;

  localparam int         DEPTH    = 4;
  localparam int         GAP      = 4;
  localparam int         TO       = 32;
  localparam int         INF      = 1 << 30;
  localparam logic [3:0] PRE_BITS = 4'b1101;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [3:0] req_delay;
  logic       req_ready;
  logic       ser_data;
  logic       ack;
  logic       tmr_counting;
  logic       tmr_done;
  logic       busy;
  logic [7:0] cmd_done_cnt;
  logic       timeout_err;

  timer_cmd_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_delay    (req_delay),
    .req_ready    (req_ready),
    .ser_data     (ser_data),
    .ack          (ack),
    .tmr_counting (tmr_counting),
    .tmr_done     (tmr_done),
    .busy         (busy),
    .cmd_done_cnt (cmd_done_cnt),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: everything is a cycle number or a queue.
  int         cyc         = 0;
  int         m_q[$];
  int         lat_q[$];
  int         m_pop       = -100;
  int         m_ws        = INF;
  int         m_lat       = 0;
  bit         m_active    = 1'b0;
  int         m_idle_from = 0;
  int         m_ack_cyc   = -1;
  int         m_acks      = 0;
  logic [3:0] m_cur       = '0;
  logic [7:0] m_cnt       = '0;
  logic       m_err       = 1'b0;
  logic [8:0] ser_hist    = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check this cycle's outputs, drive this cycle's inputs,
  // then advance the model with what the DUT will see at the next edge.
  task automatic step(input logic rst, input logic v, input logic [3:0] d);
    logic [8:0] fr;
    logic       exp_ser, exp_ready, drv_done;
    int         k;
    @(negedge clk);
    cyc++;
    fr        = {PRE_BITS, 1'b0, m_cur};
    k         = cyc - m_pop - 1;
    exp_ser   = (k >= 0 && k < 9) ? fr[8-k] : 1'b0;
    exp_ready = (m_q.size() < DEPTH);
    chk("outs", {req_ready, busy, ser_data, ack, timeout_err, cmd_done_cnt},
        {exp_ready, (cyc < m_idle_from), exp_ser, (cyc == m_ack_cyc), m_err, m_cnt});
    ser_hist = {ser_hist[7:0], ser_data};

    drv_done     = m_active && (cyc >= m_ws + m_lat);
    reset        = rst;
    req_valid    = v;
    req_delay    = d;
    tmr_done     = drv_done;
    tmr_counting = m_active && !drv_done && (cyc >= m_ws);

    if (rst) begin
      m_q.delete();
      m_pop       = -100;
      m_ws        = INF;
      m_active    = 1'b0;
      m_idle_from = cyc + 1;
      m_ack_cyc   = -1;
      m_acks      = 0;
      m_cnt       = '0;
      m_err       = 1'b0;
      return;
    end

    if (cyc >= m_idle_from && m_q.size() > 0) begin
      m_cur       = 4'(m_q.pop_front());
      m_pop       = cyc;
      m_ws        = cyc + 10;
      m_idle_from = INF;
      m_active    = 1'b1;
      m_lat       = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(0, 6)) - 2;
    end else if (m_active && cyc >= m_ws) begin
      if (drv_done) begin
        m_ack_cyc   = cyc + 1;
        m_idle_from = cyc + 2 + GAP;
        m_active    = 1'b0;
      end else if (cyc - m_ws == TO - 1) begin
        m_err       = 1'b1;
        m_idle_from = cyc + 1 + GAP;
        m_active    = 1'b0;
      end
    end
    if (v && exp_ready) m_q.push_back(int'(d));
    if (cyc == m_ack_cyc) begin
      m_cnt++;
      m_acks++;
    end
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && !(m_q.size() == 0 && !m_active && cyc >= m_idle_from); i++)
      step(1'b0, 1'b0, 4'h0);
    if (!(m_q.size() == 0 && !m_active && cyc >= m_idle_from)) chk("drain_budget", 0, 1);
  endtask

  logic [3:0] burst [5] = '{4'h3, 4'h7, 4'h0, 4'hF, 4'h1};

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_delay = '0; tmr_done = 1'b0; tmr_counting = 1'b0;
    repeat (3) step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    chk("rst_fifo_count", 32'(dut.u_fifo.count), 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);

    // Single frame with delay A.
    lat_q = '{3};
    step(1'b0, 1'b1, 4'hA);
    for (int i = 0; i < 50 && (m_pop < 0 || cyc < m_pop + 9); i++) step(1'b0, 1'b0, 4'h0);
    chk("frame_A", ser_hist, 9'h1AA);
    chk("busy_in_frame", busy, 1);
    drain(200);
    chk("cnt_after_A", cmd_done_cnt, 1);

    // Overflow burst while the previous frame waits; done-on-entry, timeout
    // and done-at-expiry latencies on the queued frames.
    lat_q = '{20, 1, -2, 1000, TO - 1};
    step(1'b0, 1'b1, 4'h9);
    for (int i = 0; i < 60 && !(m_active && cyc >= m_ws); i++) step(1'b0, 1'b0, 4'h0);
    foreach (burst[i]) step(1'b0, 1'b1, burst[i]);
    chk("full_ready", req_ready, 0);
    chk("full_count", 32'(dut.u_fifo.count), 4);
    drain(1000);
    chk("err_sticky", timeout_err, 1);
    chk("cnt_after_burst", cmd_done_cnt, 5);

    // Simultaneous push and pop with two entries queued.
    lat_q = '{4, 4};
    step(1'b0, 1'b1, 4'h5);
    step(1'b0, 1'b1, 4'h6);
    step(1'b0, 1'b1, 4'h7);
    for (int i = 0; i < 200 && cyc + 1 < m_idle_from; i++) step(1'b0, 1'b0, 4'h0);
    if (cyc + 1 < m_idle_from) chk("pp_budget", 0, 1);
    step(1'b0, 1'b1, 4'h8);
    step(1'b0, 1'b0, 4'h0);
    chk("pp_count", 32'(dut.u_fifo.count), 2);

    // Reset during payload bit [2] of the frame now in flight.
    for (int i = 0; i < 50 && cyc + 1 < m_pop + 7; i++) step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    chk("rst_mid_ser", ser_data, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_fifo", 32'(dut.u_fifo.count), 0);
    chk("rst_mid_err", timeout_err, 0);
    chk("rst_mid_cnt", cmd_done_cnt, 0);

    // Random traffic until the acknowledge counter wraps.
    for (int i = 0; i < 20000 && m_acks < 256; i++)
      step(1'b0, ($urandom_range(0, 3) == 0), 4'($urandom));
    if (m_acks == 256) begin
      step(1'b0, 1'b0, 4'h0);
      chk("cnt_wrap", cmd_done_cnt, 0);
    end else begin
      chk("ack_budget", 32'(m_acks), 256);
    end
    drain(1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
